// File: rtl/execute_pkg.sv
// Shared types and constants for the LEGv8 execute stage.
package execute_pkg;
    localparam int DATA_W = 64;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100
    } alu_op_t;
endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the execute stage; EXEC_FLAGS_EN adds the {N,Z,C,V} flag output.
module alu
    import execute_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [3:0]   i_op,
    output logic [N-1:0] o_result,
    output logic         o_zero
`ifdef EXEC_FLAGS_EN
    ,
    output logic [3:0]   o_flags
`endif
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_PASSB: o_result = i_b;
            ALU_NOR:   o_result = ~(i_a | i_b);
            default:   o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

`ifdef EXEC_FLAGS_EN
    logic [N:0] w_sum;
    logic [N:0] w_dif;
    logic       w_c;
    logic       w_v;

    // Subtraction as A + ~B + 1 so the carry-out is the inverted borrow.
    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + {{N{1'b0}}, 1'b1};

    always_comb begin
        w_c = 1'b0;
        w_v = 1'b0;
        if (i_op == ALU_ADD) begin
            w_c = w_sum[N];
            w_v = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
        end else if (i_op == ALU_SUB) begin
            w_c = w_dif[N];
            w_v = (i_a[N-1] != i_b[N-1]) && (w_dif[N-1] != i_a[N-1]);
        end
    end

    assign o_flags = {o_result[N-1], o_zero, w_c, w_v};
`endif

endmodule

// File: rtl/execute_stage.sv
// LEGv8 EX stage: operand select, ALU, branch target and store data into the EX/MEM register.
// Optional macro EXEC_FLAGS_EN adds the registered flags_E output.
module execute_stage
    import execute_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    output logic [N-1:0] PCBranch_E,
    output logic [N-1:0] aluResult_E,
    output logic [N-1:0] writeData_E,
    output logic         zero_E
`ifdef EXEC_FLAGS_EN
    ,
    output logic [3:0]   flags_E
`endif
);

    logic [N-1:0] w_opb;
    logic [N-1:0] w_alu_result;
    logic         w_alu_zero;
    logic [N-1:0] w_pc_branch;

    logic [N-1:0] r_pc_branch_p1;
    logic [N-1:0] r_alu_result_p1;
    logic [N-1:0] r_write_data_p1;
    logic         r_zero_p1;

    assign w_opb       = AluSrc ? signImm_E : readData2_E;
    assign w_pc_branch = PC_E + {signImm_E[N-3:0], 2'b00};

`ifdef EXEC_FLAGS_EN
    logic [3:0] w_alu_flags;
    logic [3:0] r_flags_p1;

    alu #(.N(N)) u_alu (
        .i_a      (readData1_E),
        .i_b      (w_opb),
        .i_op     (AluControl),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero),
        .o_flags  (w_alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags_p1 <= '0;
        end else if (en) begin
            r_flags_p1 <= w_alu_flags;
        end
    end

    assign flags_E = r_flags_p1;
`else
    alu #(.N(N)) u_alu (
        .i_a      (readData1_E),
        .i_b      (w_opb),
        .i_op     (AluControl),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );
`endif

    // EX/MEM boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_branch_p1  <= '0;
            r_alu_result_p1 <= '0;
            r_write_data_p1 <= '0;
            r_zero_p1       <= 1'b0;
        end else if (en) begin
            r_pc_branch_p1  <= w_pc_branch;
            r_alu_result_p1 <= w_alu_result;
            r_write_data_p1 <= readData2_E;
            r_zero_p1       <= w_alu_zero;
        end
    end

    assign PCBranch_E  = r_pc_branch_p1;
    assign aluResult_E = r_alu_result_p1;
    assign writeData_E = r_write_data_p1;
    assign zero_E      = r_zero_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against a behavioural EX/MEM model.
module tb_execute_stage;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         AluSrc;
    logic [3:0]   AluControl;
    logic [N-1:0] PC_E;
    logic [N-1:0] signImm_E;
    logic [N-1:0] readData1_E;
    logic [N-1:0] readData2_E;
    logic [N-1:0] PCBranch_E;
    logic [N-1:0] aluResult_E;
    logic [N-1:0] writeData_E;
    logic         zero_E;
`ifdef EXEC_FLAGS_EN
    logic [3:0]   flags_E;
    logic [3:0]   e_fl;
`endif

    always #5 clk = ~clk;

    execute_stage #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .AluSrc      (AluSrc),
        .AluControl  (AluControl),
        .PC_E        (PC_E),
        .signImm_E   (signImm_E),
        .readData1_E (readData1_E),
        .readData2_E (readData2_E),
        .PCBranch_E  (PCBranch_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .zero_E      (zero_E)
`ifdef EXEC_FLAGS_EN
        ,
        .flags_E     (flags_E)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0] e_pcb, e_alu, e_wd;
    logic         e_z;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            4'b1100: return ~(a | b);
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_clear();
        e_pcb = '0; e_alu = '0; e_wd = '0; e_z = 1'b0;
`ifdef EXEC_FLAGS_EN
        e_fl = '0;
`endif
    endtask

    task automatic model_capture();
        logic [63:0] b;
        b     = AluSrc ? signImm_E : readData2_E;
        e_alu = ref_alu(AluControl, readData1_E, b);
        e_z   = (e_alu == 64'd0);
        e_pcb = PC_E + signImm_E * 64'd4;
        e_wd  = readData2_E;
`ifdef EXEC_FLAGS_EN
        begin
            logic signed [64:0] s;
            logic c, v;
            c = 1'b0; v = 1'b0;
            if (AluControl == 4'b0010) begin
                c = ({1'b0, readData1_E} + {1'b0, b}) > 65'h0_FFFF_FFFF_FFFF_FFFF;
                s = $signed({readData1_E[63], readData1_E}) + $signed({b[63], b});
                v = (s > 65'sd9223372036854775807) || (s < -65'sd9223372036854775808);
            end else if (AluControl == 4'b0110) begin
                c = (readData1_E >= b);
                s = $signed({readData1_E[63], readData1_E}) - $signed({b[63], b});
                v = (s > 65'sd9223372036854775807) || (s < -65'sd9223372036854775808);
            end
            e_fl = {e_alu[63], e_z, c, v};
        end
`endif
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_pcb"}, PCBranch_E, e_pcb);
        check({tag, "_alu"}, aluResult_E, e_alu);
        check({tag, "_wd"}, writeData_E, e_wd);
        check({tag, "_zero"}, {63'd0, zero_E}, {63'd0, e_z});
`ifdef EXEC_FLAGS_EN
        check({tag, "_flags"}, {60'd0, flags_E}, {60'd0, e_fl});
`endif
    endtask

    task automatic drive(input logic e, input logic src, input logic [3:0] op,
                         input logic [63:0] pc, input logic [63:0] imm,
                         input logic [63:0] a, input logic [63:0] b);
        en = e; AluSrc = src; AluControl = op;
        PC_E = pc; signImm_E = imm; readData1_E = a; readData2_E = b;
    endtask

    task automatic cycle(input string tag);
        if (rst_n && en) model_capture();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 255));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [3:0] ops [7];
        logic [63:0] a, b;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0000};

        rst_n = 1'b1;
        drive(1'b1, 1'b1, 4'b0010, 64'h1234, 64'h55, 64'h99, 64'h77);
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs("reset_async");
        cycle("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 1'b0, 4'b0010, 64'd0, 64'd4, 64'd16, 64'd24);
        cycle("add_reg");
        check("add_reg_const", aluResult_E, 64'd40);
        check("add_reg_pcb_const", PCBranch_E, 64'd16);

        drive(1'b1, 1'b1, 4'b0010, 64'd0, 64'd4, 64'd16, 64'd24);
        cycle("add_imm");
        check("add_imm_const", aluResult_E, 64'd20);
        check("add_imm_wd_const", writeData_E, 64'd24);

        drive(1'b1, 1'b0, 4'b0110, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd24, 64'd24);
        cycle("sub_zero");
        check("sub_zero_z_const", {63'd0, zero_E}, 64'd1);

        drive(1'b1, 1'b0, 4'b0110, 64'hC000_0000_0000_0000, 64'h4000_0000_0000_0001, 64'd0, 64'd1);
        cycle("sub_wrap");
        check("sub_wrap_const", aluResult_E, 64'hFFFF_FFFF_FFFF_FFFF);

        drive(1'b1, 1'b0, 4'b0010, 64'd8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        cycle("add_wrap");
        check("add_wrap_z_const", {63'd0, zero_E}, 64'd1);

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 4'b1100, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom});
            cycle("stall");
        end
        en = 1'b1;
        cycle("stall_release");

        drive(1'b1, 1'b0, 4'b0111, 64'd40, 64'd2, 64'd5, 64'd9);
        cycle("pre_midreset");
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs("midreset");
        cycle("midreset_edge");
        #1 rst_n = 1'b1;
        cycle("after_midreset");

        for (int i = 0; i < 400; i++) begin
            a = pick_operand();
            b = pick_operand();
            if ($urandom_range(0, 7) == 0) b = a;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 5)],
                  {$urandom, $urandom}, pick_operand(), a, b);
            cycle("rand");
            if ($urandom_range(0, 24) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_clear();
                check_outputs("rand_reset");
                #2 rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage of a 64-bit LEGv8-style datapath.
- Selects the ALU second operand (register or sign-extended immediate), performs the ALU operation, computes the branch target PC + (imm << 2), and forwards store data.
- All results are captured in an output register, the EX/MEM boundary, with one-cycle latency and a stall enable.

Parameters:
- N, 64, datapath width (all data/PC ports).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable; 0 = stall (hold outputs).
- AluSrc  in  1  0: operand B = readData2_E; 1: operand B = signImm_E.
- AluControl  in  4  ALU operation select.
- PC_E  in  N  PC of the instruction in EX.
- signImm_E  in  N  sign-extended immediate/offset.
- readData1_E  in  N  register operand A.
- readData2_E  in  N  register operand B / store data.
- PCBranch_E  out  N  registered PC_E + (signImm_E << 2).
- aluResult_E  out  N  registered ALU result.
- writeData_E  out  N  registered readData2_E.
- zero_E  out  1  registered (ALU result == 0).

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0 immediately and held while low. Release takes effect on the next rising edge.
- Operand B is combinational: B = AluSrc ? signImm_E : readData2_E.
- ALU encodings, all modulo 2^N with no exceptions:
  - 0000 A & B
  - 0001 A | B
  - 0010 A + B
  - 0110 A - B
  - 0111 pass B
  - 1100 ~(A | B)
  - any other code: result 0.
- zero = (result == 0), computed on the selected operation's result.
- Branch target = PC_E + (signImm_E << 2). The shift drops the top two bits and the add wraps mod 2^N. It is independent of AluSrc and AluControl.
- writeData = readData2_E, unaffected by AluSrc.
- Latency: each rising edge with en=1 and rst_n=1 registers all four outputs from the current inputs. Results appear one cycle after the inputs are presented.
- en=0: all outputs hold their previous values.
- Reset asserted mid-operation overrides en and clears outputs at once; any pending capture is discarded.
- Wrap examples:
  - A = 2^64 - 1, B = 1, ADD → result 0, zero = 1.
  - A = 0, B = 1, SUB → result all-ones, zero = 0.
- No X propagation: unknown inputs are not special-cased.

Optional Feature:
- Macro EXEC_FLAGS_EN.
- Defined: adds output port flags_E [3:0] = {N, Z, C, V}, registered like the other outputs and cleared on reset.
  - N = result[N-1].
  - Z = zero.
  - C = carry-out for ADD, or NOT borrow for SUB (A >= B unsigned); 0 for logical operations.
  - V = signed overflow for ADD/SUB; 0 otherwise.
- Undefined: no flags_E port, no flag logic; the block is otherwise identical.

Decomposition:
- Shared package execute_pkg:
  - typedef alu_op_t (4-bit enum): ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_PASSB = 4'b0111, ALU_NOR = 4'b1100.
  - constant DATA_W = 64.
- One sub-module: alu, purely combinational (a, b, op → result, zero, and flags when EXEC_FLAGS_EN is defined), instantiated once inside execute_stage.

Test Plan:
- Reset: rst_n=0 asynchronously with nonzero inputs → all outputs 0 immediately, before any clock edge.
- Register ADD: AluControl=0010, AluSrc=0, readData1_E=16, readData2_E=24, signImm_E=4, PC_E=0, en=1, one edge → aluResult_E=40, writeData_E=24, PCBranch_E=16, zero_E=0.
- Immediate ADD: same inputs with AluSrc=1, one edge → aluResult_E=20, writeData_E=24, PCBranch_E=16.
- SUB to zero: A=24, B=24, AluControl=0110 → aluResult_E=0, zero_E=1.
- SUB wrap: A=0, B=1, AluControl=0110 → all-ones, zero_E=0.
- Stall: en=0, change all inputs, clock 3 edges → outputs unchanged; en=1 → new values captured after 1 edge.
